// File: rtl/ball_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ball_controller
//
// Frame-level brain of the ball. Each frame it issues STEPS_PER_FRAME one-pixel
// move commands to the ball position register, separated by hold cycles so the
// new position is visible before the next decision. Before each move it checks
// the current ball centre against the walls, both paddle faces and both goal
// lines, flips the direction bits as needed, and on a miss pulses the scoring
// output and asks the position register to re-centre the ball.
//
// Ports
//   clk              system clock
//   reset_n          synchronous, active-low reset
//   frame_tick       one-cycle pulse per video frame; starts a burst of moves
//   serve            level; starts a volley while the controller is waiting
//   ball_center_x/y  current ball centre from the position register
//   paddle_l_y/r_y   top row of the left / right paddle
//   cw_ballMovement  registered control word for the position register:
//                      0000 hold, 0001 +x+y, 0010 -x-y, 0011 -x+y,
//                      0100 +x-y, 0101 recentre
//   score_l          one-cycle pulse: ball left through the right goal line
//   score_r          one-cycle pulse: ball left through the left goal line
//   in_play          high from serve acceptance until a miss
// -----------------------------------------------------------------------------
module ball_controller #(
    parameter int SCREEN_W        = 640,
    parameter int SCREEN_H        = 480,
    parameter int BALL_R          = 4,
    parameter int PADDLE_H        = 64,
    parameter int PADDLE_L_FACE   = 24,
    parameter int PADDLE_R_FACE   = 616,
    parameter int STEPS_PER_FRAME = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       serve,
    input  logic [9:0] ball_center_x,
    input  logic [9:0] ball_center_y,
    input  logic [9:0] paddle_l_y,
    input  logic [9:0] paddle_r_y,
    output logic [3:0] cw_ballMovement,
    output logic       score_l,
    output logic       score_r,
    output logic       in_play
);

    // -------------------------------------------------------------------------
    // Control-word encoding understood by the position register
    // -------------------------------------------------------------------------
    localparam logic [3:0] CW_HOLD     = 4'b0000;
    localparam logic [3:0] CW_PXPY     = 4'b0001;
    localparam logic [3:0] CW_NXNY     = 4'b0010;
    localparam logic [3:0] CW_NXPY     = 4'b0011;
    localparam logic [3:0] CW_PXNY     = 4'b0100;
    localparam logic [3:0] CW_RECENTRE = 4'b0101;

    // -------------------------------------------------------------------------
    // Geometry thresholds. Everything is compared at 11 bits so that adding the
    // ball radius or the paddle span to a 10-bit coordinate never wraps.
    // -------------------------------------------------------------------------
    localparam logic [10:0] L_HIT_X    = 11'(PADDLE_L_FACE + BALL_R);
    localparam logic [10:0] R_HIT_X    = 11'(PADDLE_R_FACE - BALL_R);
    localparam logic [10:0] L_GOAL_X   = 11'(BALL_R);
    localparam logic [10:0] R_GOAL_X   = 11'(SCREEN_W - 1 - BALL_R);
    localparam logic [10:0] TOP_WALL_Y = 11'(BALL_R);
    localparam logic [10:0] BOT_WALL_Y = 11'(SCREEN_H - 1 - BALL_R);
    localparam logic [10:0] BALL_R_W   = 11'(BALL_R);
    // The ball's leading edge (y + r) must fall inside the paddle span widened
    // by the full ball height, so a ball grazing either paddle corner still hits.
    localparam logic [10:0] PAD_SPAN   = 11'(PADDLE_H - 1 + 2 * BALL_R);
    localparam logic [3:0]  STEP_LOAD  = 4'(STEPS_PER_FRAME);

    typedef enum logic [2:0] {
        S_RECENTRE,
        S_WAIT,
        S_PLAY,
        S_STEP,
        S_GAP
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        dir_x;         // 1 = moving toward +x
    logic        dir_y;         // 1 = moving toward +y
    logic [3:0]  step_cnt;

    logic        dir_x_next;
    logic        dir_y_next;
    logic [3:0]  step_cnt_next;
    logic [3:0]  cw_next;
    logic        score_l_next;
    logic        score_r_next;
    logic        in_play_next;

    // -------------------------------------------------------------------------
    // Collision detection on the current inputs
    // -------------------------------------------------------------------------
    logic [10:0] x_w;
    logic [10:0] y_w;
    logic [10:0] y_lead;
    logic [10:0] pl_top;
    logic [10:0] pl_bot;
    logic [10:0] pr_top;
    logic [10:0] pr_bot;

    logic        hit_l;
    logic        hit_r;
    logic        miss_l;
    logic        miss_r;
    logic        wall_top;
    logic        wall_bot;

    assign x_w    = {1'b0, ball_center_x};
    assign y_w    = {1'b0, ball_center_y};
    assign y_lead = y_w + BALL_R_W;
    assign pl_top = {1'b0, paddle_l_y};
    assign pl_bot = pl_top + PAD_SPAN;
    assign pr_top = {1'b0, paddle_r_y};
    assign pr_bot = pr_top + PAD_SPAN;

    assign hit_l  = !dir_x && (x_w <= L_HIT_X) &&
                    (y_lead >= pl_top) && (y_lead <= pl_bot);
    assign hit_r  =  dir_x && (x_w >= R_HIT_X) &&
                    (y_lead >= pr_top) && (y_lead <= pr_bot);

    // A paddle return takes priority over a goal-line crossing.
    assign miss_l = !dir_x && !hit_l && (x_w <= L_GOAL_X);
    assign miss_r =  dir_x && !hit_r && (x_w >= R_GOAL_X);

    assign wall_top = !dir_y && (y_w <= TOP_WALL_Y);
    assign wall_bot =  dir_y && (y_w >= BOT_WALL_Y);

    function automatic logic [3:0] cw_of(input logic dx, input logic dy);
        logic [3:0] cw;
        unique case ({dx, dy})
            2'b11:   cw = CW_PXPY;
            2'b00:   cw = CW_NXNY;
            2'b01:   cw = CW_NXPY;
            default: cw = CW_PXNY;
        endcase
        return cw;
    endfunction

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all of them update from the same
        // pre-edge values; blocking = would leak new values into later lines.
        if (!reset_n) begin
            state           <= S_RECENTRE;
            dir_x           <= 1'b1;
            dir_y           <= 1'b1;
            step_cnt        <= '0;
            cw_ballMovement <= CW_HOLD;
            score_l         <= 1'b0;
            score_r         <= 1'b0;
            in_play         <= 1'b0;
        end else begin
            state           <= state_next;
            dir_x           <= dir_x_next;
            dir_y           <= dir_y_next;
            step_cnt        <= step_cnt_next;
            cw_ballMovement <= cw_next;
            score_l         <= score_l_next;
            score_r         <= score_r_next;
            in_play         <= in_play_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: a default assignment ahead of the case keeps every path
        // assigned, so no latch is inferred for unlisted states or conditions.
        state_next = state;
        unique case (state)
            S_RECENTRE: state_next = S_WAIT;
            S_WAIT:     if (serve)      state_next = S_PLAY;
            S_PLAY:     if (frame_tick) state_next = S_STEP;
            S_STEP:     state_next = (miss_l || miss_r) ? S_RECENTRE : S_GAP;
            S_GAP:      state_next = (step_cnt == '0) ? S_PLAY : S_STEP;
            default:    state_next = S_RECENTRE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath logic: values registered at the next edge
    // -------------------------------------------------------------------------
    always_comb begin
        dir_x_next    = dir_x;
        dir_y_next    = dir_y;
        step_cnt_next = step_cnt;
        cw_next       = CW_HOLD;
        score_l_next  = 1'b0;
        score_r_next  = 1'b0;
        in_play_next  = in_play;

        unique case (state)
            S_RECENTRE: cw_next = CW_RECENTRE;

            S_WAIT: if (serve) in_play_next = 1'b1;

            S_PLAY: if (frame_tick) step_cnt_next = STEP_LOAD;

            S_STEP: begin
                step_cnt_next = step_cnt - 4'd1;
                if (miss_l) begin
                    // Ball went out on the left: right player scores and the
                    // next serve heads left, toward the player who conceded.
                    score_r_next = 1'b1;
                    in_play_next = 1'b0;
                    dir_x_next   = 1'b0;
                end else if (miss_r) begin
                    score_l_next = 1'b1;
                    in_play_next = 1'b0;
                    dir_x_next   = 1'b1;
                end else begin
                    // Paddle and wall flips are independent so a corner hit
                    // reverses both axes in the same step.
                    if (hit_l)
                        dir_x_next = 1'b1;
                    else if (hit_r)
                        dir_x_next = 1'b0;

                    if (wall_top)
                        dir_y_next = 1'b1;
                    else if (wall_bot)
                        dir_y_next = 1'b0;

                    cw_next = cw_of(dir_x_next, dir_y_next);
                end
            end

            default: ;
        endcase
    end

endmodule

// File: tb/tb_ball_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_ball_controller
//
// Plays the role of the ball position register (applies each move word to its
// own copy of the ball position) and predicts the controller's decisions from
// the game rules: bounce off walls and paddle faces, score on a goal-line
// crossing. Directed table vectors, hand-written corner sequences and a
// randomised rally are all compared against those predictions.
// -----------------------------------------------------------------------------
module tb_ball_controller;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int BALL_R   = 4;
    localparam int PADDLE_H = 64;
    localparam int L_FACE   = 24;
    localparam int R_FACE   = 616;
    localparam int STEPS    = 2;

    logic       clk        = 1'b0;
    logic       reset_n    = 1'b0;
    logic       frame_tick = 1'b0;
    logic       serve      = 1'b0;
    logic [9:0] bx         = 10'd320;
    logic [9:0] by         = 10'd240;
    logic [9:0] pl         = 10'd0;
    logic [9:0] pr         = 10'd0;
    logic [3:0] cw;
    logic       score_l;
    logic       score_r;
    logic       in_play;

    int n_checks = 0;
    int n_err    = 0;

    // Reference direction of travel (1 = positive axis).
    bit m_dx = 1'b1;
    bit m_dy = 1'b1;

    ball_controller #(
        .SCREEN_W       (SCREEN_W),
        .SCREEN_H       (SCREEN_H),
        .BALL_R         (BALL_R),
        .PADDLE_H       (PADDLE_H),
        .PADDLE_L_FACE  (L_FACE),
        .PADDLE_R_FACE  (R_FACE),
        .STEPS_PER_FRAME(STEPS)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .frame_tick     (frame_tick),
        .serve          (serve),
        .ball_center_x  (bx),
        .ball_center_y  (by),
        .paddle_l_y     (pl),
        .paddle_r_y     (pr),
        .cw_ballMovement(cw),
        .score_l        (score_l),
        .score_r        (score_r),
        .in_play        (in_play)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Position register behaviour for one move word.
    task automatic apply_move(input logic [3:0] c);
        case (c)
            4'h1: begin bx = bx + 10'd1; by = by + 10'd1; end
            4'h2: begin bx = bx - 10'd1; by = by - 10'd1; end
            4'h3: begin bx = bx - 10'd1; by = by + 10'd1; end
            4'h4: begin bx = bx + 10'd1; by = by - 10'd1; end
            4'h5: begin bx = 10'd320;    by = 10'd240;    end
            default: ;
        endcase
    endtask

    function automatic logic [3:0] word_for(input bit dx, input bit dy);
        if (dx && dy)  return 4'h1;
        if (!dx && !dy) return 4'h2;
        if (!dx && dy) return 4'h3;
        return 4'h4;
    endfunction

    // Rule-level prediction of one step from the current ball/paddle inputs.
    task automatic model_expect(output logic [3:0] e_cw, output bit e_sl, output bit e_sr);
        int x;
        int y;
        int lead;
        bit hl;
        bit hr;
        x    = int'(bx);
        y    = int'(by);
        lead = y + BALL_R;
        hl   = !m_dx && x <= L_FACE + BALL_R &&
               lead >= int'(pl) && lead <= int'(pl) + PADDLE_H - 1 + 2 * BALL_R;
        hr   =  m_dx && x >= R_FACE - BALL_R &&
               lead >= int'(pr) && lead <= int'(pr) + PADDLE_H - 1 + 2 * BALL_R;
        e_cw = 4'h0;
        e_sl = 1'b0;
        e_sr = 1'b0;
        if (!hl && !hr && !m_dx && x <= BALL_R) begin
            e_sr = 1'b1;
        end else if (!hl && !hr && m_dx && x >= SCREEN_W - 1 - BALL_R) begin
            e_sl = 1'b1;
        end else begin
            if (hl) m_dx = 1'b1;
            if (hr) m_dx = 1'b0;
            if (!m_dy && y <= BALL_R) m_dy = 1'b1;
            else if (m_dy && y >= SCREEN_H - 1 - BALL_R) m_dy = 1'b0;
            e_cw = word_for(m_dx, m_dy);
        end
    endtask

    // One step: entered just after the edge that put the controller into its
    // step slot; returns just after the following hold (or the recentre hold).
    task automatic do_step(input string name, input logic [3:0] e_cw, input bit e_sl, input bit e_sr);
        @(posedge clk); #1;
        check({name, "_cw"},      cw,      e_cw);
        check({name, "_score_l"}, score_l, e_sl);
        check({name, "_score_r"}, score_r, e_sr);
        if (e_sl || e_sr) begin
            check({name, "_inplay_drop"}, in_play, 0);
            @(posedge clk); #1;
            check({name, "_recentre"}, cw, 4'h5);
            check({name, "_score_once"}, score_l | score_r, 0);
            @(posedge clk); #1;
            check({name, "_wait_hold"}, cw, 4'h0);
            apply_move(4'h5);
        end else begin
            check({name, "_inplay"}, in_play, 1);
            @(posedge clk); #1;
            check({name, "_gap"}, cw, 4'h0);
            apply_move(e_cw);
        end
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic model_frame(input string name, output bit missed);
        logic [3:0] e_cw;
        bit         e_sl;
        bit         e_sr;
        missed = 1'b0;
        pulse_tick();
        for (int s = 0; s < STEPS && !missed; s++) begin
            model_expect(e_cw, e_sl, e_sr);
            do_step(name, e_cw, e_sl, e_sr);
            missed = e_sl || e_sr;
        end
    endtask

    task automatic do_serve();
        serve = 1'b1;
        @(posedge clk); #1;
        serve = 1'b0;
        check("serve_inplay", in_play, 1);
        check("serve_hold",   cw,      4'h0);
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        serve      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cw",      cw,      4'h0);
        check("rst_inplay",  in_play, 0);
        check("rst_score_l", score_l, 0);
        check("rst_score_r", score_r, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_recentre", cw, 4'h5);
        @(posedge clk); #1;
        check("rst_wait_cw",     cw,      4'h0);
        check("rst_wait_inplay", in_play, 0);
        m_dx = 1'b1;
        m_dy = 1'b1;
    endtask

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] pl;
        logic [9:0] pr;
        logic [3:0] cw;
    } vec_t;

    vec_t vecs[12];

    initial begin
        bit missed;
        int frames;

        // Consecutive steps (two per frame) starting from direction (+x,+y).
        vecs[0]  = '{10'd320, 10'd220, 10'd0,   10'd0,   4'h1}; // free flight
        vecs[1]  = '{10'd321, 10'd221, 10'd0,   10'd0,   4'h1};
        vecs[2]  = '{10'd400, 10'd475, 10'd0,   10'd0,   4'h4}; // bottom wall
        vecs[3]  = '{10'd400, 10'd4,   10'd0,   10'd0,   4'h1}; // top wall
        vecs[4]  = '{10'd400, 10'd475, 10'd0,   10'd0,   4'h4}; // bottom wall
        vecs[5]  = '{10'd612, 10'd4,   10'd0,   10'd0,   4'h3}; // right paddle + top
        vecs[6]  = '{10'd300, 10'd200, 10'd200, 10'd0,   4'h3};
        vecs[7]  = '{10'd29,  10'd230, 10'd200, 10'd0,   4'h3}; // one px short of face
        vecs[8]  = '{10'd28,  10'd230, 10'd200, 10'd0,   4'h1}; // left paddle
        vecs[9]  = '{10'd200, 10'd476, 10'd0,   10'd0,   4'h4};
        vecs[10] = '{10'd612, 10'd300, 10'd0,   10'd233, 4'h2}; // right paddle lowest row
        vecs[11] = '{10'd24,  10'd200, 10'd205, 10'd0,   4'h2}; // above left paddle

        do_reset();

        // frame_tick is ignored while waiting for a serve.
        pulse_tick();
        check("wait_tick_cw", cw, 4'h0);
        @(posedge clk); #1;
        check("wait_tick_cw2",     cw,      4'h0);
        check("wait_tick_inplay", in_play, 0);

        do_serve();

        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) pulse_tick();
            bx = vecs[i].x;
            by = vecs[i].y;
            pl = vecs[i].pl;
            pr = vecs[i].pr;
            do_step($sformatf("vec%0d", i), vecs[i].cw, 1'b0, 1'b0);
        end

        // Holds in PLAY between frames.
        repeat (3) begin
            @(posedge clk); #1;
            check("play_hold_cw",     cw,      4'h0);
            check("play_hold_inplay", in_play, 1);
        end

        // Reset asserted during the hold cycle after a move.
        pulse_tick();
        bx = 10'd320; by = 10'd220; pl = 10'd0; pr = 10'd0;
        @(posedge clk); #1;
        check("gaprst_move", cw, 4'h2);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("gaprst_cw",      cw,      4'h0);
        check("gaprst_inplay",  in_play, 0);
        check("gaprst_score_l", score_l, 0);
        check("gaprst_score_r", score_r, 0);
        do_reset();

        // Right paddle turns the ball, then it runs past a raised left paddle.
        do_serve();
        bx = 10'd612; by = 10'd100; pr = 10'd80; pl = 10'd0;
        model_frame("rpad", missed);
        bx = 10'd28; by = 10'd230; pl = 10'd300;
        frames = 0;
        missed = 1'b0;
        while (!missed && frames < 40) begin
            model_frame("lmiss", missed);
            frames++;
        end
        check("lmiss_seen",   missed, 1);
        check("lmiss_frames", frames, 13);

        // Randomised rally against the rule model.
        do_serve();
        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 2))
                    0:       bx = 10'($urandom_range(0, 40));
                    1:       bx = 10'($urandom_range(599, 639));
                    default: bx = 10'($urandom_range(0, 639));
                endcase
                case ($urandom_range(0, 2))
                    0:       by = 10'($urandom_range(0, 12));
                    1:       by = 10'($urandom_range(467, 479));
                    default: by = 10'($urandom_range(0, 479));
                endcase
                pl = 10'($urandom_range(0, 415));
                pr = 10'($urandom_range(0, 415));
            end
            model_frame("rand", missed);
            if (missed) do_serve();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
